// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI mode-0 bus master.
package spi_master_pkg;

  // Default frame length in bits
  localparam int DATA_WIDTH_DEF = 32;

  // Frame sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: a SCLK_HALF-cycle counter that produces a wrap tick,
// rise/fall strobes for the coming SCLK edge, and the registered SCLK
// itself. While run_i is low the counter and SCLK are held at zero, so the
// first tick after enabling lands exactly SCLK_HALF cycles later. With
// toggle_en_i low the counter keeps ticking but SCLK stays low (used for the
// trailing chip-select hold period).
module spi_sclk_gen #(
  parameter int SCLK_HALF = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic toggle_en_i,
  output logic tick_o,
  output logic rise_o,
  output logic fall_o,
  output logic sclk_o
);

  localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          wrap_s;

  assign wrap_s = run_i && (cnt_q == CW'(SCLK_HALF - 1));
  assign tick_o = wrap_s;
  assign rise_o = wrap_s && toggle_en_i && !sclk_q;
  assign fall_o = wrap_s && toggle_en_i && sclk_q;
  assign sclk_o = sclk_q;

  // Next-state for the half-period counter and SCLK level
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!run_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (wrap_s) begin
      cnt_d = '0;
      if (toggle_en_i) begin
        sclk_d = ~sclk_q;
      end else begin
        sclk_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter and SCLK registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Single-channel SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// A 0->1 edge of sendStart in IDLE launches one DATA_WIDTH-bit frame.
// Optional build macro: SPI_MASTER_LOOPBACK_EN -- when defined the receive
// shift register samples the internal MOSI instead of SPI_MISO, so recvData
// returns the transmitted word; the pins still toggle normally.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SCLK_HALF  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sendStart,
  input  logic [DATA_WIDTH-1:0] sendData,
  output logic [DATA_WIDTH-1:0] recvData,
  output logic                  busy,
  output logic                  done,
  output logic                  SPI_SCLK,
  output logic                  SPI_MOSI,
  input  logic                  SPI_MISO,
  output logic                  SPI_CS
);

  localparam int BW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] recv_q, recv_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_q, cs_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  start_prev_q;

  logic start_s;
  logic rx_in_s;
  logic tick_s, rise_s, fall_s;
  logic run_s, toggle_en_s;

  assign start_s     = sendStart && !start_prev_q;
  assign run_s       = (state_q == SHIFT) || (state_q == HOLD);
  assign toggle_en_s = (state_q == SHIFT);

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_in_s = mosi_q;
`else
  assign rx_in_s = SPI_MISO;
`endif

  spi_sclk_gen #(
    .SCLK_HALF (SCLK_HALF)
  ) u_sclk_gen (
    .clk_i       (clk),
    .rst_i       (rst),
    .run_i       (run_s),
    .toggle_en_i (toggle_en_s),
    .tick_o      (tick_s),
    .rise_o      (rise_s),
    .fall_o      (fall_s),
    .sclk_o      (SPI_SCLK)
  );

  // Frame FSM next-state plus all datapath next values
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    recv_d  = recv_q;
    bit_d   = bit_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = SHIFT;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          tx_d    = sendData;
          mosi_d  = sendData[DATA_WIDTH-1];
          rx_d    = '0;
          bit_d   = '0;
        end else begin
          mosi_d = 1'b0;
        end
      end
      SHIFT: begin
        if (rise_s) begin
          // Capture happens on the same clk edge that raises SCLK, so the
          // slave's bit from before the edge is what lands here.
          rx_d = {rx_q[DATA_WIDTH-2:0], rx_in_s};
        end else if (fall_s) begin
          tx_d   = tx_q << 1;
          mosi_d = tx_q[DATA_WIDTH-2];
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            state_d = HOLD;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          state_d = SHIFT;
        end
      end
      HOLD: begin
        if (tick_s) begin
          state_d = IDLE;
          cs_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          recv_d  = rx_q;
          mosi_d  = 1'b0;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        cs_d    = 1'b1;
        busy_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and start-edge registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tx_q         <= '0;
      rx_q         <= '0;
      recv_q       <= '0;
      bit_q        <= '0;
      mosi_q       <= 1'b0;
      cs_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      recv_q       <= recv_d;
      bit_q        <= bit_d;
      mosi_q       <= mosi_d;
      cs_q         <= cs_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      start_prev_q <= sendStart;
    end
  end

  assign recvData = recv_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign SPI_MOSI = mosi_q;
  assign SPI_CS   = cs_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: two instances (SCLK_HALF=1 and 3),
// each with a behavioural mode-0 slave that presents its MSB on MISO and
// shifts on SCLK rise while capturing MOSI.
module tb_spi_master;

  localparam int N = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start_s [2];
  logic [N-1:0] sdata_s [2];
  logic [N-1:0] recv_w  [2];
  logic         busy_w  [2];
  logic         done_w  [2];
  logic         sclk_w  [2];
  logic         mosi_w  [2];
  logic         miso_w  [2];
  logic         cs_w    [2];

  spi_master #(.DATA_WIDTH(N), .SCLK_HALF(1)) u_dut0 (
    .clk(clk), .rst(rst), .sendStart(start_s[0]), .sendData(sdata_s[0]),
    .recvData(recv_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .SPI_SCLK(sclk_w[0]), .SPI_MOSI(mosi_w[0]), .SPI_MISO(miso_w[0]), .SPI_CS(cs_w[0])
  );

  spi_master #(.DATA_WIDTH(N), .SCLK_HALF(3)) u_dut1 (
    .clk(clk), .rst(rst), .sendStart(start_s[1]), .sendData(sdata_s[1]),
    .recvData(recv_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .SPI_SCLK(sclk_w[1]), .SPI_MOSI(mosi_w[1]), .SPI_MISO(miso_w[1]), .SPI_CS(cs_w[1])
  );

  // Behavioural slaves, cycle counter and event counters
  logic [N-1:0] slv_pre  [2];
  logic         slv_load [2];
  logic [N-1:0] slv_out  [2] = '{32'h0, 32'h0};
  logic [N-1:0] slv_in   [2] = '{32'h0, 32'h0};
  logic         prev_sclk[2] = '{1'b0, 1'b0};
  int           rises    [2] = '{0, 0};
  int           dones    [2] = '{0, 0};
  int           cyc = 0;

  assign miso_w[0] = slv_out[0][N-1];
  assign miso_w[1] = slv_out[1][N-1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 2; g++) begin
      prev_sclk[g] <= sclk_w[g];
      if (done_w[g]) dones[g] <= dones[g] + 1;
      if (slv_load[g]) begin
        slv_out[g] <= slv_pre[g];
        slv_in[g]  <= '0;
      end else if (sclk_w[g] && !prev_sclk[g]) begin
        slv_in[g]  <= {slv_in[g][N-2:0], mosi_w[g]};
        slv_out[g] <= slv_out[g] << 1;
        rises[g]   <= rises[g] + 1;
      end
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference model: frame length and received word from the protocol rules
  function automatic int half_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic logic [N-1:0] exp_rx(input logic [N-1:0] tx, input logic [N-1:0] slv);
`ifdef SPI_MASTER_LOOPBACK_EN
    return tx;
`else
    return slv;
`endif
  endfunction

  task automatic start_frame(input int g, input logic [N-1:0] tx, input logic [N-1:0] slv,
                             output int e0, output int r0);
    @(negedge clk);
    start_s[g]  = 1'b0;
    sdata_s[g]  = tx;
    slv_pre[g]  = slv;
    slv_load[g] = 1'b1;
    @(negedge clk);
    slv_load[g] = 1'b0;
    start_s[g]  = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    r0 = rises[g];
    check($sformatf("cs_low_at_start[%0d]", g), cs_w[g], 1'b0);
    check($sformatf("busy_at_start[%0d]", g), busy_w[g], 1'b1);
    check($sformatf("mosi_msb_at_start[%0d]", g), mosi_w[g], tx[N-1]);
  endtask

  task automatic finish_frame(input int g, input int e0, input int r0,
                              input logic [N-1:0] tx, input logic [N-1:0] slv);
    int waited = 0;
    while (done_w[g] !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("done_seen[%0d]", g), (waited < 2000), 1'b1);
    check($sformatf("latency[%0d]", g), cyc - e0, half_of(g) * (2 * N + 1));
    check($sformatf("cs_high_at_done[%0d]", g), cs_w[g], 1'b1);
    check($sformatf("busy_at_done[%0d]", g), busy_w[g], 1'b0);
    check($sformatf("recvData[%0d]", g), recv_w[g], exp_rx(tx, slv));
    check($sformatf("slave_rx[%0d]", g), slv_in[g], tx);
    check($sformatf("sclk_rises[%0d]", g), rises[g] - r0, N);
    @(negedge clk);
    check($sformatf("done_one_cycle[%0d]", g), done_w[g], 1'b0);
  endtask

  task automatic run_frame(input int g, input logic [N-1:0] tx, input logic [N-1:0] slv);
    int e0, r0;
    start_frame(g, tx, slv, e0, r0);
    finish_frame(g, e0, r0, tx, slv);
  endtask

  typedef struct {
    int           g;
    logic [N-1:0] tx;
    logic [N-1:0] slv;
  } vec_t;

  vec_t vt [6];

  initial begin
    int e0, r0, d0;
    vt[0] = '{0, 32'h12345678, 32'hFEDCBA98};
    vt[1] = '{0, 32'hFFFFFFFF, 32'h00000000};
    vt[2] = '{0, 32'h00000000, 32'hFFFFFFFF};
    vt[3] = '{0, 32'h80000001, 32'h55AA55AA};
    vt[4] = '{1, 32'hA5A5A5A5, 32'h3C3CC3C3};
    vt[5] = '{1, 32'h00000001, 32'h80000000};

    // Reset with sendStart held high on both instances
    rst = 1'b1;
    start_s  = '{1'b1, 1'b1};
    sdata_s  = '{32'h0, 32'h0};
    slv_pre  = '{32'h0, 32'h0};
    slv_load = '{1'b0, 1'b0};
    repeat (3) @(negedge clk);
    check("rst_cs", cs_w[0], 1'b1);
    check("rst_sclk", sclk_w[0], 1'b0);
    check("rst_mosi", mosi_w[0], 1'b0);
    check("rst_recv", recv_w[0], 32'h0);
    check("rst_busy", busy_w[0], 1'b0);
    check("rst_done", done_w[0], 1'b0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("held_through_reset_no_frame0", dones[0], 0);
    check("held_through_reset_no_frame1", dones[1], 0);
    check("held_through_reset_cs", cs_w[1], 1'b1);

    // Table-driven frames
    for (int i = 0; i < 6; i++) run_frame(vt[i].g, vt[i].tx, vt[i].slv);

    // Randomised frames on both instances
    for (int i = 0; i < 8; i++) begin
      int g;
      logic [N-1:0] tx, slv;
      g   = int'($urandom_range(1, 0));
      tx  = $urandom();
      slv = $urandom();
      run_frame(g, tx, slv);
    end

    // sendStart held high for 200 cycles gives a single frame; a fresh edge gives another
    d0 = dones[0];
    run_frame(0, 32'hC0FFEE11, 32'h0BADF00D);
    repeat (130) @(negedge clk);
    check("held_start_one_frame", dones[0] - d0, 1);
    run_frame(0, 32'h13579BDF, 32'h2468ACE0);
    check("restart_second_frame", dones[0] - d0, 2);

    // sendData change and start re-pulse mid-frame are ignored
    d0 = dones[0];
    start_frame(0, 32'hCAFEBABE, 32'h76543210, e0, r0);
    repeat (10) @(negedge clk);
    sdata_s[0] = 32'h0F0F0F0F;
    start_s[0] = 1'b0;
    @(negedge clk);
    start_s[0] = 1'b1;
    finish_frame(0, e0, r0, 32'hCAFEBABE, 32'h76543210);
    repeat (80) @(negedge clk);
    check("no_queued_frame", dones[0] - d0, 1);
    check("idle_after_ignored_start", cs_w[0], 1'b1);

    // Reset mid-frame: outputs return to reset values at once
    start_frame(0, 32'h89ABCDEF, 32'h11223344, e0, r0);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_cs", cs_w[0], 1'b1);
    check("midrst_sclk", sclk_w[0], 1'b0);
    check("midrst_mosi", mosi_w[0], 1'b0);
    check("midrst_busy", busy_w[0], 1'b0);
    check("midrst_recv", recv_w[0], 32'h0);
    start_s[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_frame(0, 32'h5A5AF00F, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
